// File: rtl/recip_pkg.sv
// Shared Q4.28 constants, FSM state type and saturating helpers for the
// Newton-Raphson reciprocal sequencer.
package recip_pkg;

    localparam logic [31:0] ONE     = 32'h1000_0000;
    localparam logic [31:0] TWO     = 32'h2000_0000;
    localparam logic [31:0] C48_17  = 32'h2D2D_2D2D;
    localparam logic [31:0] CN32_17 = 32'hE1E1_E1E2;
    localparam logic [31:0] QMAX    = 32'h7FFF_FFFF;
    localparam logic [31:0] QMIN    = 32'h8000_0000;

    localparam logic [9:0]  FUNC_RECIP = 10'd1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SEED  = 3'd1,
        MUL_A = 3'd2,
        MUL_B = 3'd3,
        RESP  = 3'd4
    } state_t;

    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] s;
        s = a + b;
        // Overflow only when both operands share a sign the sum does not.
        if ((a[31] == b[31]) && (s[31] != a[31]))
            return a[31] ? QMIN : QMAX;
        return s;
    endfunction

    function automatic logic [31:0] sat_neg(input logic [31:0] a);
        if (a == QMIN)
            return QMAX;
        return (~a) + 32'd1;
    endfunction

endpackage

// File: rtl/qmul_sat.sv
// Combinational saturating Q4.28 multiply: signed 64-bit product, bits [59:28],
// clamped when the discarded integer bits are not a pure sign extension.
module qmul_sat
    import recip_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] p
);

    logic signed [63:0] prod;

    assign prod = $signed(a) * $signed(b);

    always_comb begin
        if (prod[63:59] == {5{prod[63]}})
            p = prod[59:28];
        else
            p = prod[63] ? QMIN : QMAX;
    end

endmodule

// File: rtl/recip_nr_seq.sv
// Sequential Q4.28 reciprocal: linear seed followed by ITERS Newton-Raphson
// steps on h = d/2, sharing one saturating multiplier across all states.
//
// state | meaning
// IDLE  | waiting for a command, cmd_ready high
// SEED  | y = 48/17 - 32/17 * h
// MUL_A | t = h * y
// MUL_B | y = y * (2 - t), count one iteration
// RESP  | result presented until rsp_ready
module recip_nr_seq
    import recip_pkg::*;
#(
    parameter int ITERS = 3
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [9:0]  cmd_payload_function_id,
    input  logic [31:0] cmd_payload_inputs_0,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_payload_outputs_0
);

    state_t      state;
    state_t      state_nxt;
    logic [2:0]  cnt;
    logic [3:0]  cnt_inc;
    logic        more_iters;
    logic [31:0] h;
    logic [31:0] y;
    logic [31:0] t;
    logic [31:0] res;
    logic [31:0] mul_a;
    logic [31:0] mul_b;
    logic [31:0] mul_p;
    logic        is_recip;
    logic        in_range;

    assign is_recip   = (cmd_payload_function_id == FUNC_RECIP);
    assign in_range   = ($signed(cmd_payload_inputs_0) >= $signed(ONE)) &&
                        ($signed(cmd_payload_inputs_0) <= $signed(TWO));
    assign cnt_inc    = {1'b0, cnt} + 4'd1;
    assign more_iters = (cnt_inc < 4'(ITERS));

    always_comb begin
        mul_a = '0;
        mul_b = '0;
        case (state)
            SEED: begin
                mul_a = CN32_17;
                mul_b = h;
            end
            MUL_A: begin
                mul_a = h;
                mul_b = y;
            end
            MUL_B: begin
                mul_a = y;
                mul_b = sat_add(TWO, sat_neg(t));
            end
            default: ;
        endcase
    end

    qmul_sat u_qmul (
        .a (mul_a),
        .b (mul_b),
        .p (mul_p)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (cmd_valid)
                    state_nxt = (is_recip && in_range) ? SEED : RESP;
            end
            SEED:  state_nxt = MUL_A;
            MUL_A: state_nxt = MUL_B;
            MUL_B: state_nxt = more_iters ? MUL_A : RESP;
            RESP: begin
                if (rsp_ready)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = (state == IDLE);
        rsp_valid = (state == RESP);
    end

    // res is loaded once when RESP is entered, so it is stable for the whole hold.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
            h   <= '0;
            y   <= '0;
            t   <= '0;
            res <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        if (is_recip && in_range)
                            h <= {1'b0, cmd_payload_inputs_0[31:1]};
                        else if (is_recip)
                            res <= QMAX;
                        else
                            res <= '0;
                    end
                end
                SEED: begin
                    y   <= sat_add(C48_17, mul_p);
                    cnt <= '0;
                end
                MUL_A: t <= mul_p;
                MUL_B: begin
                    y   <= mul_p;
                    cnt <= cnt_inc[2:0];
                    if (!more_iters)
                        res <= {mul_p[31], mul_p[31:1]};
                end
                default: ;
            endcase
        end
    end

    assign rsp_payload_outputs_0 = res;

endmodule

// File: doc/recip_nr_seq.md
RECIP_NR_SEQ -- requirements
Module: recip_nr_seq

Interface
REQ-001 SHALL have parameter ITERS, default 3, meaning the number of Newton-Raphson iterations (legal range 1..7).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port cmd_valid, input, 1 bit: command present.
REQ-005 SHALL have port cmd_ready, output, 1 bit: block can accept a command.
REQ-006 SHALL have port cmd_payload_function_id, input, 10 bits: operation select.
REQ-007 SHALL have port cmd_payload_inputs_0, input, 32 bits: divisor d, Q4.28 two's complement.
REQ-008 SHALL have port rsp_valid, output, 1 bit: result present.
REQ-009 SHALL have port rsp_ready, input, 1 bit: consumer accepts the result.
REQ-010 SHALL have port rsp_payload_outputs_0, output, 32 bits: result, Q4.28.

Function
REQ-011 SHALL compute 1/d in Q4.28 using one shared saturating Q4.28 multiplier, time-multiplexed at one multiply per cycle.
REQ-012 SHALL implement an FSM with states IDLE, SEED, MUL_A, MUL_B and RESP, plus a 3-bit iteration counter.
REQ-013 SHALL assert cmd_ready only in IDLE; a command is accepted on the rising edge where cmd_valid && cmd_ready.
REQ-014 On accept with function_id==1 and 0x10000000 <= d <= 0x20000000: SHALL capture h=d>>1 and go to SEED.
REQ-015 SEED SHALL set y <= sat_add(0x2D2D2D2D, mul(0xE1E1E1E2, h)), clear the counter, and go to MUL_A.
REQ-016 MUL_A SHALL set t <= mul(h, y) and go to MUL_B.
REQ-017 MUL_B SHALL set y <= mul(y, sat_add(0x20000000, sat_neg(t))) and increment the counter.
- Goes to MUL_A if counter+1 < ITERS, otherwise to RESP.
REQ-018 RESP SHALL drive rsp_payload_outputs_0 = y >>> 1 (arithmetic shift right by 1).
REQ-019 Latency for the valid range SHALL be exactly 2*ITERS+1 rising edges from the accept edge to the first cycle of rsp_valid=1 (7 for ITERS=3).
REQ-020 On accept with function_id==1 and d outside [0x10000000, 0x20000000] (including zero and negative d), SHALL go directly to RESP.
- Result is 0x7FFFFFFF; rsp_valid rises 1 edge after accept.
REQ-021 On accept with any other function_id, SHALL go directly to RESP with result 0x00000000 (latency 1).
REQ-022 rsp_valid SHALL equal (state==RESP); the result SHALL be held stable while rsp_valid && !rsp_ready.
REQ-023 SHALL return from RESP to IDLE on the edge where rsp_valid && rsp_ready; cmd_ready rises in the following cycle (one-cycle bubble, no same-edge overlap).
REQ-024 Command inputs SHALL be ignored in every state except IDLE.
REQ-025 mul SHALL form the signed 64-bit product and take bits [59:28].
- Saturates to 0x7FFFFFFF / 0x80000000 when bits [63:59] are not all equal.
REQ-026 sat_add SHALL saturate on signed overflow; sat_neg(0x80000000) SHALL equal 0x7FFFFFFF.
REQ-027 For in-range d, the result SHALL be within 16 LSB of round(2^28/d).

Reset
REQ-028 reset_n=0 SHALL asynchronously force the following:
- state=IDLE;
- cmd_ready=1, rsp_valid=0, rsp_payload_outputs_0=0;
- counter=0, h=0, y=0, t=0.
REQ-029 Reset asserted mid-operation SHALL abort the operation with no response; the first command after release SHALL be processed normally.

Structure
REQ-030 Package recip_pkg SHALL hold:
- Q4.28 constants ONE=0x10000000, TWO=0x20000000, C48_17=0x2D2D2D2D, CN32_17=0xE1E1E1E2, QMAX=0x7FFFFFFF, QMIN=0x80000000;
- FUNC_RECIP=10'd1;
- the FSM state typedef.
REQ-031 SHALL instantiate exactly one combinational sub-module, qmul_sat (saturating Q4.28 multiply), with operands muxed by state.
- sat_add and sat_neg SHALL be package functions.

Verification
REQ-032 d=0x10000000, rsp_ready=1 -> rsp_valid rises exactly 7 edges after accept; result 0x10000000±16.
REQ-033 d=0x20000000 -> result 0x08000000±16; d=0x18000000 -> result 0x0AAAAAAA±16.
REQ-034 d=0x00000000, then d=0xF0000000 -> each returns 0x7FFFFFFF, 1 edge after accept.
REQ-035 function_id=5 -> result 0x00000000, latency 1; cmd_ready=0 during every non-IDLE cycle.
REQ-036 Hold rsp_ready=0 for 10 cycles in RESP -> rsp_valid and the result stay stable and cmd_ready=0; the new command accepted only after the handshake plus a 1-cycle bubble.
REQ-037 reset_n=0 during MUL_B of iteration 2 -> all outputs take their reset values immediately; no response is produced; the next d=0x10000000 completes correctly.
